// File: rtl/down_counter_ctrl.sv
// Sequencing controller for the mod-2^WIDTH down counter: load, prescaled decrement,
// pause/resume, abort, and one-shot or auto-reload operation with a terminal-count pulse.
module down_counter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode_periodic,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic [1:0]       state
);

  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           st_q, st_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tc_d;
  logic             tick;

  function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] v);
    return v - WIDTH'(1);
  endfunction

  assign tick  = (psc_q == PSC_LAST);
  assign state = st_q;
  assign busy  = (st_q == S_RUN) || (st_q == S_HOLD);

  always_comb begin
    st_d       = st_q;
    count_d    = count;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    psc_d      = psc_q;
    tc_d       = 1'b0;
    case (st_q)
      S_IDLE, S_DONE: begin
        if (abort && (st_q == S_DONE)) begin
          st_d    = S_IDLE;
          count_d = '0;
          psc_d   = '0;
        end else if (start && (load_val != '0)) begin
          st_d       = S_RUN;
          count_d    = load_val;
          reload_d   = load_val;
          periodic_d = mode_periodic;
          psc_d      = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          st_d    = S_IDLE;
          count_d = '0;
          psc_d   = '0;
        end else if (pause) begin
          st_d = S_HOLD;
        end else if (tick) begin
          psc_d = '0;
          // Terminal transition at 1 so the count never has to wrap below zero.
          if (count == WIDTH'(1)) begin
            tc_d = 1'b1;
            if (periodic_q) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              st_d    = S_DONE;
            end
          end else begin
            count_d = dec_wrap(count);
          end
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end
      end
      S_HOLD: begin
        if (abort) begin
          st_d    = S_IDLE;
          count_d = '0;
          psc_d   = '0;
        end else if (!pause) begin
          st_d = S_RUN;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_q       <= S_IDLE;
      count      <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      psc_q      <= '0;
      tc         <= 1'b0;
    end else begin
      st_q       <= st_d;
      count      <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      psc_q      <= psc_d;
      tc         <= tc_d;
    end
  end

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Bench for down_counter_ctrl: directed scenarios on PRESCALE=1 and PRESCALE=4 instances,
// then randomized traffic checked against a cycle-level behavioural model.
module tb_down_counter_ctrl;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic       start1, per1, pause1, abort1;
  logic [3:0] lv1;
  logic [3:0] count1;
  logic       busy1, tc1;
  logic [1:0] state1;

  logic       start4, per4, pause4, abort4;
  logic [3:0] lv4;
  logic [3:0] count4;
  logic       busy4, tc4;
  logic [1:0] state4;

  down_counter_ctrl #(.WIDTH(4), .PRESCALE(1)) u1 (
    .clk(clk), .clr(clr), .start(start1), .load_val(lv1), .mode_periodic(per1),
    .pause(pause1), .abort(abort1), .count(count1), .busy(busy1), .tc(tc1), .state(state1)
  );

  down_counter_ctrl #(.WIDTH(4), .PRESCALE(4)) u4 (
    .clk(clk), .clr(clr), .start(start4), .load_val(lv4), .mode_periodic(per4),
    .pause(pause4), .abort(abort4), .count(count4), .busy(busy4), .tc(tc4), .state(state4)
  );

  wire [7:0] obs1 = {count1, state1, busy1, tc1};
  wire [7:0] obs4 = {count4, state4, busy4, tc4};

  int n_checks = 0;
  int n_fail   = 0;

  // Expected observation: count, state, busy (high in RUN/HOLD), tc.
  function automatic logic [7:0] pack(input int c, input int s, input bit t);
    logic [3:0] cv;
    logic [1:0] sv;
    cv = c[3:0];
    sv = s[1:0];
    return {cv, sv, (s == 1 || s == 2), t};
  endfunction

  typedef struct {
    int st;
    int cnt;
    int el;
    int rl;
    bit per;
    bit tc;
  } mdl_t;

  // One clock of the controller as described by its rules: el counts RUN cycles since the last decrement.
  function automatic mdl_t mstep(input mdl_t m, input int presc, input bit st_rq, input int lv,
                                 input bit per, input bit pau, input bit abt);
    mdl_t n;
    n = m;
    n.tc = 0;
    if (abt && m.st != 0) begin
      n.st = 0; n.cnt = 0; n.el = 0;
    end else if (m.st == 0 || m.st == 3) begin
      if (st_rq && lv != 0) begin
        n.st = 1; n.cnt = lv; n.rl = lv; n.per = per; n.el = 0;
      end
    end else if (m.st == 2) begin
      if (!pau) n.st = 1;
    end else if (pau) begin
      n.st = 2;
    end else begin
      n.el = m.el + 1;
      if (n.el == presc) begin
        n.el = 0;
        if (m.cnt == 1) begin
          n.tc = 1;
          if (m.per) n.cnt = m.rl;
          else begin n.cnt = 0; n.st = 3; end
        end else begin
          n.cnt = m.cnt - 1;
        end
      end
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int guard;
    clr = 1'b1;
    start1 = 0; lv1 = 0; per1 = 0; pause1 = 0; abort1 = 0;
    start4 = 0; lv4 = 0; per4 = 0; pause4 = 0; abort4 = 0;
    #12;
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL reset_u1 got=%b exp=%b", obs1, pack(0, 0, 0)); end
    n_checks++;
    if (obs4 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL reset_u4 got=%b exp=%b", obs4, pack(0, 0, 0)); end
    clr = 1'b0;
    step();
    start1 = 1; lv1 = 4'd12; per1 = 0;
    step();
    start1 = 0;
    guard = 0;
    while (count1 !== 4'd9 && guard < 10) begin step(); guard++; end
    n_checks++;
    if (obs1 !== pack(9, 1, 0)) begin n_fail++; $display("FAIL reset_reach9 got=%b exp=%b", obs1, pack(9, 1, 0)); end
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL reset_async got=%b exp=%b", obs1, pack(0, 0, 0)); end
    #9 clr = 1'b0;
    step();
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL reset_after got=%b exp=%b", obs1, pack(0, 0, 0)); end
  endtask

  task automatic test_oneshot();
    start1 = 1; lv1 = 4'd5; per1 = 0;
    step();
    start1 = 0;
    n_checks++;
    if (obs1 !== pack(5, 1, 0)) begin n_fail++; $display("FAIL oneshot_load got=%b exp=%b", obs1, pack(5, 1, 0)); end
    for (int v = 4; v >= 0; v--) begin
      step();
      n_checks++;
      if (obs1 !== pack(v, (v == 0) ? 3 : 1, v == 0)) begin
        n_fail++; $display("FAIL oneshot_dec got=%b exp=%b", obs1, pack(v, (v == 0) ? 3 : 1, v == 0));
      end
    end
    step();
    n_checks++;
    if (obs1 !== pack(0, 3, 0)) begin n_fail++; $display("FAIL oneshot_done got=%b exp=%b", obs1, pack(0, 3, 0)); end
  endtask

  task automatic test_periodic();
    int v;
    start1 = 1; lv1 = 4'd3; per1 = 1;
    step();
    start1 = 0; per1 = 0;
    n_checks++;
    if (obs1 !== pack(3, 1, 0)) begin n_fail++; $display("FAIL periodic_load got=%b exp=%b", obs1, pack(3, 1, 0)); end
    for (int k = 1; k <= 8; k++) begin
      step();
      v = (k % 3 == 0) ? 3 : 3 - (k % 3);
      n_checks++;
      if (obs1 !== pack(v, 1, k % 3 == 0)) begin
        n_fail++; $display("FAIL periodic_seq got=%b exp=%b", obs1, pack(v, 1, k % 3 == 0));
      end
    end
    abort1 = 1;
    step();
    abort1 = 0;
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL periodic_abort got=%b exp=%b", obs1, pack(0, 0, 0)); end
  endtask

  task automatic test_pause();
    int v, run;
    start1 = 1; lv1 = 4'd15; per1 = 0;
    step();
    start1 = 0;
    run = 0;
    for (v = 14; v >= 12; v--) begin
      step(); run++;
      n_checks++;
      if (obs1 !== pack(v, 1, 0)) begin n_fail++; $display("FAIL pause_pre got=%b exp=%b", obs1, pack(v, 1, 0)); end
    end
    pause1 = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (obs1 !== pack(12, 2, 0)) begin n_fail++; $display("FAIL pause_hold got=%b exp=%b", obs1, pack(12, 2, 0)); end
    end
    pause1 = 0;
    step();
    n_checks++;
    if (obs1 !== pack(12, 1, 0)) begin n_fail++; $display("FAIL pause_resume got=%b exp=%b", obs1, pack(12, 1, 0)); end
    v = 12;
    while (run < 30) begin
      step(); run++; v--;
      n_checks++;
      if (obs1 !== pack(v, (v == 0) ? 3 : 1, v == 0)) begin
        n_fail++; $display("FAIL pause_post got=%b exp=%b", obs1, pack(v, (v == 0) ? 3 : 1, v == 0));
      end
      if (tc1 === 1'b1 || v <= 0) break;
    end
    n_checks++;
    if (run != 15) begin n_fail++; $display("FAIL pause_run_cycles got=%0d exp=15", run); end
  endtask

  task automatic test_abort_zero_load();
    start1 = 1; lv1 = 4'd10; per1 = 0;
    step();
    start1 = 0;
    step(); step(); step();
    n_checks++;
    if (obs1 !== pack(7, 1, 0)) begin n_fail++; $display("FAIL abort_reach7 got=%b exp=%b", obs1, pack(7, 1, 0)); end
    abort1 = 1;
    step();
    abort1 = 0;
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL abort_run got=%b exp=%b", obs1, pack(0, 0, 0)); end
    start1 = 1; lv1 = 4'd0; per1 = 1;
    step();
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL zero_load got=%b exp=%b", obs1, pack(0, 0, 0)); end
    start1 = 0; per1 = 0;
    step();
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL zero_load_idle got=%b exp=%b", obs1, pack(0, 0, 0)); end
  endtask

  task automatic test_prescaler();
    int c;
    start4 = 1; lv4 = 4'd2; per4 = 0;
    step();
    start4 = 0;
    n_checks++;
    if (obs4 !== pack(2, 1, 0)) begin n_fail++; $display("FAIL presc_load got=%b exp=%b", obs4, pack(2, 1, 0)); end
    for (int k = 1; k <= 9; k++) begin
      step();
      c = (k >= 8) ? 0 : 2 - k / 4;
      n_checks++;
      if (obs4 !== pack(c, (k >= 8) ? 3 : 1, k == 8)) begin
        n_fail++; $display("FAIL presc_seq k=%0d got=%b exp=%b", k, obs4, pack(c, (k >= 8) ? 3 : 1, k == 8));
      end
    end
  endtask

  task automatic test_simultaneous();
    start1 = 1; lv1 = 4'd2; per1 = 0;
    step();
    start1 = 0;
    step();
    abort1 = 1;
    step();
    abort1 = 0;
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL abort_vs_tc got=%b exp=%b", obs1, pack(0, 0, 0)); end
    start1 = 1; lv1 = 4'd1;
    step();
    start1 = 0;
    pause1 = 1;
    step();
    n_checks++;
    if (obs1 !== pack(1, 2, 0)) begin n_fail++; $display("FAIL pause_vs_tc got=%b exp=%b", obs1, pack(1, 2, 0)); end
    pause1 = 0;
    step();
    step();
    n_checks++;
    if (obs1 !== pack(0, 3, 1)) begin n_fail++; $display("FAIL pause_vs_tc_late got=%b exp=%b", obs1, pack(0, 3, 1)); end
    start1 = 1; lv1 = 4'd5; abort1 = 1;
    step();
    start1 = 0; abort1 = 0;
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL start_abort_done got=%b exp=%b", obs1, pack(0, 0, 0)); end
    start1 = 1; lv1 = 4'd6; per1 = 1;
    step();
    lv1 = 4'd3;
    step();
    n_checks++;
    if (obs1 !== pack(5, 1, 0)) begin n_fail++; $display("FAIL start_in_run got=%b exp=%b", obs1, pack(5, 1, 0)); end
    pause1 = 1;
    step(); step();
    n_checks++;
    if (obs1 !== pack(5, 2, 0)) begin n_fail++; $display("FAIL start_in_hold got=%b exp=%b", obs1, pack(5, 2, 0)); end
    start1 = 0; pause1 = 0; per1 = 0; abort1 = 1;
    step();
    abort1 = 0;
    n_checks++;
    if (obs1 !== pack(0, 0, 0)) begin n_fail++; $display("FAIL abort_hold got=%b exp=%b", obs1, pack(0, 0, 0)); end
  endtask

  task automatic test_random();
    mdl_t m1, m4;
    int   nf_local;
    m1 = '{0, 0, 0, 0, 0, 0};
    m4 = '{0, 0, 0, 0, 0, 0};
    nf_local = 0;
    clr = 1'b1;
    #4 clr = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      start1 = ($urandom_range(0, 3) == 0); lv1 = 4'($urandom_range(0, 15)); per1 = 1'($urandom_range(0, 1));
      pause1 = ($urandom_range(0, 7) == 0); abort1 = ($urandom_range(0, 39) == 0);
      start4 = ($urandom_range(0, 3) == 0); lv4 = 4'($urandom_range(0, 15)); per4 = 1'($urandom_range(0, 1));
      pause4 = ($urandom_range(0, 5) == 0); abort4 = ($urandom_range(0, 59) == 0);
      m1 = mstep(m1, 1, start1, int'(lv1), per1, pause1, abort1);
      m4 = mstep(m4, 4, start4, int'(lv4), per4, pause4, abort4);
      step();
      n_checks++;
      if (obs1 !== pack(m1.cnt, m1.st, m1.tc)) begin
        n_fail++; nf_local++;
        if (nf_local < 10) $display("FAIL random_u1 cyc=%0d got=%b exp=%b", i, obs1, pack(m1.cnt, m1.st, m1.tc));
      end
      n_checks++;
      if (obs4 !== pack(m4.cnt, m4.st, m4.tc)) begin
        n_fail++; nf_local++;
        if (nf_local < 10) $display("FAIL random_u4 cyc=%0d got=%b exp=%b", i, obs4, pack(m4.cnt, m4.st, m4.tc));
      end
    end
    start1 = 0; pause1 = 0; abort1 = 0;
    start4 = 0; pause4 = 0; abort4 = 0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_abort_zero_load();
    test_prescaler();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
